multdiv_issue: RTL and testbench

MULTDIV_ISSUE -- requirements
Module: multdiv_issue

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_watchdog.sv | 40 ++++
 rtl/multdiv_issue.sv | 150 +++++++++++++++
 tb/tb_multdiv_issue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: FSM state encoding, op encoding and the watchdog default shared by
// the mult/div issue controller and its watchdog.
package multdiv_pkg;

   typedef logic [1:0] md_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 40;

endpackage

// File: rtl/multdiv_watchdog.sv
// multdiv_watchdog: WAIT-cycle counter with clear/enable and a terminal-count flag.
// Only compiled when MULTDIV_ISSUE_TIMEOUT_EN is defined.
`ifdef MULTDIV_ISSUE_TIMEOUT_EN
module multdiv_watchdog #(
   parameter int unsigned LIMIT = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic terminal_o
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // terminal_o marks the LIMIT-th enabled cycle; the count parks there until cleared
   assign terminal_o = (count_q == CNT_W'(LIMIT - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !terminal_o) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`endif

// File: rtl/multdiv_issue.sv
// multdiv_issue: issues one multiply/divide to an external unit and writes back the result.
// Define MULTDIV_ISSUE_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES cycles.
module multdiv_issue
   import multdiv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_op,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   input  logic        flush,
   output logic        issue_ready,
   output logic        stall,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("multdiv_issue: TIMEOUT_CYCLES must be at least 1");
   end

   md_state_t   state_q, state_d;
   logic        op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_exc_q, wb_exc_d;
   logic        res_exc;

   logic in_idle, in_start, in_wait, in_wb;
   assign in_idle  = (state_q == ST_IDLE);
   assign in_start = (state_q == ST_START);
   assign in_wait  = (state_q == ST_WAIT);
   assign in_wb    = (state_q == ST_WB);

`ifdef MULTDIV_ISSUE_TIMEOUT_EN
   logic wd_terminal;

   multdiv_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (!in_wait),
      .enable_i  (in_wait),
      .terminal_o(wd_terminal)
   );
`endif

   // A divide-by-zero flag is only meaningful for divides
   assign res_exc = md_exception & (op_q == OP_DIV);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      wb_exc_d  = wb_exc_q;
      case (state_q)
         ST_IDLE: begin
            if (issue_valid) begin
               op_d    = issue_op;
               rd_d    = issue_rd;
               a_d     = issue_a;
               b_d     = issue_b;
               state_d = ST_START;
            end
         end
         ST_START: begin
            state_d = flush ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            // flush beats a same-cycle result; a result beats the terminal count
            if (flush) begin
               state_d = ST_IDLE;
            end else if (md_resultRDY) begin
               wb_rd_d   = rd_q;
               wb_exc_d  = res_exc;
               wb_data_d = res_exc ? 32'd0 : md_result;
               state_d   = ST_WB;
`ifdef MULTDIV_ISSUE_TIMEOUT_EN
            end else if (wd_terminal) begin
               wb_rd_d   = rd_q;
               wb_exc_d  = 1'b1;
               wb_data_d = 32'd0;
               state_d   = ST_WB;
`endif
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULT;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         wb_exc_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_q       <= a_d;
         b_q       <= b_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         wb_exc_q  <= wb_exc_d;
      end
   end

   assign issue_ready  = in_idle;
   assign stall        = (in_idle & issue_valid) | in_start | in_wait;
   assign md_operandA  = (in_start | in_wait) ? a_q : 32'd0;
   assign md_operandB  = (in_start | in_wait) ? b_q : 32'd0;
   assign md_ctrl_MULT = in_start & (op_q == OP_MULT);
   assign md_ctrl_DIV  = in_start & (op_q == OP_DIV);
   assign wb_valid     = in_wb;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// tb_multdiv_issue: directed scoreboard bench for multdiv_issue; timeout cases are
// exercised only when MULTDIV_ISSUE_TIMEOUT_EN is defined.
module tb_multdiv_issue;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_op;
   logic [4:0]  issue_rd;
   logic [31:0] issue_a;
   logic [31:0] issue_b;
   logic        flush;
   logic        issue_ready;
   logic        stall;
   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic        md_ctrl_MULT;
   logic        md_ctrl_DIV;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exception;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exc;
   } wb_t;

   wb_t exp_q[$];
   wb_t got;
   int  checks   = 0;
   int  failures = 0;
   int  mult_pulses = 0;
   int  div_pulses  = 0;
   int  exp_mult = 0;
   int  exp_div  = 0;

   multdiv_issue #(
      .TIMEOUT_CYCLES(40)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_op    (issue_op),
      .issue_rd    (issue_rd),
      .issue_a     (issue_a),
      .issue_b     (issue_b),
      .flush       (flush),
      .issue_ready (issue_ready),
      .stall       (stall),
      .md_operandA (md_operandA),
      .md_operandB (md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT),
      .md_ctrl_DIV (md_ctrl_DIV),
      .md_result   (md_result),
      .md_exception(md_exception),
      .md_resultRDY(md_resultRDY),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_exception(wb_exception)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; checks happen 1 unit later still
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_rd    = rd;
      issue_a     = a;
      issue_b     = b;
      if (op) exp_div++;
      else    exp_mult++;
   endtask

   task automatic result(input logic [31:0] data, input logic exc);
      md_resultRDY = 1'b1;
      md_result    = data;
      md_exception = exc;
   endtask

   task automatic no_result();
      md_resultRDY = 1'b0;
      md_result    = 32'd0;
      md_exception = 1'b0;
   endtask

   // Scoreboard: every write-back is matched against the oldest expectation
   always @(negedge clock) begin
      if (md_ctrl_MULT === 1'b1) mult_pulses++;
      if (md_ctrl_DIV === 1'b1)  div_pulses++;
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid), 32'd0);
         end else begin
            got = exp_q.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(got.rd));
            chk("wb_data", wb_data, got.data);
            chk("wb_exception", 32'(wb_exception), 32'(got.exc));
            $display("wb rd=%0d data=%0h exc=%0b", wb_rd, wb_data, wb_exception);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b1;
      issue_valid = 1'b0;
      issue_op = 1'b0;
      issue_rd = '0;
      issue_a = '0;
      issue_b = '0;
      flush = 1'b0;
      no_result();
      repeat (3) tick();
      reset = 1'b0;
      settle();
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
      chk("rst_opA", md_operandA, 32'd0);

      // Multiply 7*6, result 33 cycles after START
      issue(1'b0, 5'd5, 32'd7, 32'd6);
      exp_q.push_back('{rd: 5'd5, data: 32'd42, exc: 1'b0});
      settle();
      chk("mul_idle_stall", 32'(stall), 32'd1);
      tick();
      issue_valid = 1'b0;
      settle();
      chk("mul_start_MULT", 32'(md_ctrl_MULT), 32'd1);
      chk("mul_start_DIV", 32'(md_ctrl_DIV), 32'd0);
      chk("mul_start_opA", md_operandA, 32'd7);
      chk("mul_start_opB", md_operandB, 32'd6);
      chk("mul_start_ready", 32'(issue_ready), 32'd0);
      repeat (33) tick();
      chk("mul_wait_MULT", 32'(md_ctrl_MULT), 32'd0);
      chk("mul_wait_opB", md_operandB, 32'd6);
      chk("mul_wait_stall", 32'(stall), 32'd1);
      result(32'd42, 1'b0);
      tick();
      no_result();
      settle();
      chk("mul_wb_valid", 32'(wb_valid), 32'd1);
      chk("mul_wb_stall", 32'(stall), 32'd0);
      chk("mul_wb_opA", md_operandA, 32'd0);
      tick();
      chk("mul_after_wb_valid", 32'(wb_valid), 32'd0);
      chk("mul_after_ready", 32'(issue_ready), 32'd1);

      // Divide by zero at minimum latency
      issue(1'b1, 5'd9, 32'd10, 32'd0);
      exp_q.push_back('{rd: 5'd9, data: 32'd0, exc: 1'b1});
      tick();
      issue_valid = 1'b0;
      settle();
      chk("div_start_DIV", 32'(md_ctrl_DIV), 32'd1);
      chk("div_start_MULT", 32'(md_ctrl_MULT), 32'd0);
      tick();
      result(32'hDEADBEEF, 1'b1);
      tick();
      no_result();
      settle();
      chk("div_wb_valid", 32'(wb_valid), 32'd1);
      tick();

      // Exception flag on a multiply is not a divide-by-zero
      issue(1'b0, 5'd3, 32'd10, 32'd10);
      exp_q.push_back('{rd: 5'd3, data: 32'd100, exc: 1'b0});
      tick();
      issue_valid = 1'b0;
      tick();
      result(32'd100, 1'b1);
      tick();
      no_result();
      tick();

      // Flush together with the result in WAIT
      issue(1'b1, 5'd4, 32'd20, 32'd3);
      tick();
      issue_valid = 1'b0;
      tick();
      flush = 1'b1;
      result(32'd6, 1'b0);
      tick();
      flush = 1'b0;
      no_result();
      settle();
      chk("flushw_wb_valid", 32'(wb_valid), 32'd0);
      chk("flushw_ready", 32'(issue_ready), 32'd1);
      chk("flushw_opA", md_operandA, 32'd0);
      tick();

      // Flush in START
      issue(1'b1, 5'd8, 32'd1, 32'd1);
      tick();
      issue_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      chk("flushs_ready", 32'(issue_ready), 32'd1);
      chk("flushs_stall", 32'(stall), 32'd0);
      tick();

      // Flush in IDLE does not block the issue
      issue(1'b0, 5'd7, 32'd3, 32'd4);
      exp_q.push_back('{rd: 5'd7, data: 32'd12, exc: 1'b0});
      flush = 1'b1;
      tick();
      issue_valid = 1'b0;
      flush = 1'b0;
      settle();
      chk("flushi_MULT", 32'(md_ctrl_MULT), 32'd1);
      tick();
      result(32'd12, 1'b0);
      tick();
      no_result();
      tick();

      // Stale result pulse in START, real one 5 cycles later
      issue(1'b0, 5'd11, 32'd2, 32'd9);
      exp_q.push_back('{rd: 5'd11, data: 32'd18, exc: 1'b0});
      tick();
      issue_valid = 1'b0;
      result(32'd999, 1'b0);
      tick();
      no_result();
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("stale_no_wb", 32'(wb_valid), 32'd0);
         tick();
      end
      result(32'd18, 1'b0);
      tick();
      no_result();
      settle();
      chk("stale_wb_valid", 32'(wb_valid), 32'd1);
      tick();

      // Reset in WAIT, with a result arriving the same cycle
      issue(1'b1, 5'd13, 32'd5, 32'd5);
      tick();
      issue_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      result(32'd1, 1'b0);
      tick();
      reset = 1'b0;
      no_result();
      settle();
      chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
      chk("rstw_wb_data", wb_data, 32'd0);
      chk("rstw_wb_rd", 32'(wb_rd), 32'd0);
      chk("rstw_wb_exc", 32'(wb_exception), 32'd0);
      chk("rstw_opA", md_operandA, 32'd0);
      chk("rstw_stall", 32'(stall), 32'd0);
      chk("rstw_ready", 32'(issue_ready), 32'd1);
      repeat (3) tick();

`ifdef MULTDIV_ISSUE_TIMEOUT_EN
      // No result: watchdog ends the operation after 40 WAIT cycles
      issue(1'b1, 5'd2, 32'd9, 32'd3);
      exp_q.push_back('{rd: 5'd2, data: 32'd0, exc: 1'b1});
      tick();
      issue_valid = 1'b0;
      repeat (40) tick();
      chk("tmo_w40_no_wb", 32'(wb_valid), 32'd0);
      tick();
      chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
      tick();

      // Result on the terminal count cycle wins
      issue(1'b0, 5'd6, 32'd7, 32'd11);
      exp_q.push_back('{rd: 5'd6, data: 32'd77, exc: 1'b0});
      tick();
      issue_valid = 1'b0;
      repeat (40) tick();
      result(32'd77, 1'b0);
      tick();
      no_result();
      settle();
      chk("tmo_term_wb_valid", 32'(wb_valid), 32'd1);
      tick();
`endif

      repeat (2) tick();
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("mult_pulses", mult_pulses, exp_mult);
      chk("div_pulses", div_pulses, exp_div);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
